// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit: access sizes, FSM states,
// byte counts, store-data alignment and load-data extension.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_t;

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SIZE_B:  byte_count = 3'd1;
      SIZE_H:  byte_count = 3'd2;
      default: byte_count = 3'd4;
    endcase
  endfunction

  // Left-justify the right-aligned store field so the first byte to send sits in [31:24].
  function automatic logic [31:0] align_store(input logic [31:0] wdata, input logic [1:0] size);
    case (size)
      SIZE_B:  align_store = {wdata[7:0], 24'h000000};
      SIZE_H:  align_store = {wdata[15:0], 16'h0000};
      default: align_store = wdata;
    endcase
  endfunction

  function automatic logic [31:0] extend_data(input logic [31:0] acc, input logic [1:0] size,
                                              input logic is_unsigned);
    case (size)
      SIZE_B:  extend_data = {{24{acc[7] & ~is_unsigned}}, acc[7:0]};
      SIZE_H:  extend_data = {{16{acc[15] & ~is_unsigned}}, acc[15:0]};
      default: extend_data = acc;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational sign/zero extension of an assembled load value by access size.
import lsu_pkg::*;

module lsu_extend (
  input  logic [31:0] acc,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  assign data = extend_data(acc, size, is_unsigned);

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage access sequencer: runs each load/store as single-byte big-endian memory
// cycles and returns extended load data or an error through a valid/ready response.
import lsu_pkg::*;

module load_store_unit #(
  parameter int MEM_ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_we,
  input  logic [1:0]            cpu_req_size,
  input  logic                  cpu_req_unsigned,
  input  logic [31:0]           cpu_req_addr,
  input  logic [31:0]           cpu_req_wdata,
  output logic                  cpu_resp_valid,
  input  logic                  cpu_resp_ready,
  output logic [31:0]           cpu_resp_rdata,
  output logic                  cpu_resp_error,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic [1:0]            dbg_state
);

  localparam logic [MEM_ADDR_W-1:0] ADDR_ONE = 1;

  lsu_state_t  state, state_nxt;
  logic        req_we, req_uns;
  logic [1:0]  req_size;
  logic [2:0]  req_n, idx;
  logic [23:0] acc;
  logic [31:0] wsh;
  logic [31:0] acc_nxt, ext_data, store_aligned;
  logic [2:0]  new_n;
  logic [32:0] end_addr;
  logic        req_err, req_fire, resp_fire, last_byte;

  assign new_n         = byte_count(cpu_req_size);
  assign end_addr      = {1'b0, cpu_req_addr} + {30'd0, new_n} - 33'd1;
  assign store_aligned = align_store(cpu_req_wdata, cpu_req_size);
  assign req_err = (cpu_req_size == SIZE_X) ||
                   ((cpu_req_size == SIZE_H) && cpu_req_addr[0]) ||
                   ((cpu_req_size == SIZE_W) && (cpu_req_addr[1:0] != 2'b00)) ||
                   (end_addr[32:MEM_ADDR_W] != '0);

  assign last_byte = (idx == (req_n - 3'd1));
  assign acc_nxt   = {acc, mem_rdata};
  assign dbg_state = state;

  lsu_extend u_extend (
    .acc         (acc_nxt),
    .size        (req_size),
    .is_unsigned (req_uns),
    .data        (ext_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the initiator holds its payload stable while valid is high and ready is low.
  always_comb begin
    state_nxt      = state;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    req_fire       = 1'b0;
    resp_fire      = 1'b0;
    case (state)
      ST_IDLE: begin
        cpu_req_ready = reset_n;
        if (cpu_req_valid) begin
          req_fire  = 1'b1;
          state_nxt = req_err ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (last_byte) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        cpu_resp_valid = 1'b1;
        if (cpu_resp_ready) begin
          resp_fire = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_we         <= 1'b0;
      req_uns        <= 1'b0;
      req_size       <= SIZE_B;
      req_n          <= 3'd1;
      idx            <= 3'd0;
      acc            <= 24'h0;
      wsh            <= 32'h0;
      mem_addr       <= '0;
      mem_we         <= 1'b0;
      mem_wdata      <= 8'h00;
      cpu_resp_rdata <= 32'h0;
      cpu_resp_error <= 1'b0;
    end else if (req_fire) begin
      req_we   <= cpu_req_we;
      req_uns  <= cpu_req_unsigned;
      req_size <= cpu_req_size;
      req_n    <= new_n;
      idx      <= 3'd0;
      acc      <= 24'h0;
      if (req_err) begin
        cpu_resp_error <= 1'b1;
        cpu_resp_rdata <= 32'h0;
      end else begin
        mem_addr  <= cpu_req_addr[MEM_ADDR_W-1:0];
        mem_we    <= cpu_req_we;
        mem_wdata <= cpu_req_we ? store_aligned[31:24] : 8'h00;
        wsh       <= {store_aligned[23:0], 8'h00};
      end
    end else if (state == ST_ACCESS) begin
      acc <= acc_nxt[23:0];
      if (last_byte) begin
        mem_we         <= 1'b0;
        mem_wdata      <= 8'h00;
        cpu_resp_rdata <= req_we ? 32'h0 : ext_data;
      end else begin
        idx       <= idx + 3'd1;
        mem_addr  <= mem_addr + ADDR_ONE;
        mem_wdata <= req_we ? wsh[31:24] : 8'h00;
        wsh       <= {wsh[23:0], 8'h00};
      end
    end else if (resp_fire) begin
      cpu_resp_rdata <= 32'h0;
      cpu_resp_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-wide memory model, table of requests with expected
// responses, randomized store/load pairs, response stall and mid-access reset sequences.
import lsu_pkg::*;

module tb_load_store_unit;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  logic        clk, reset_n;
  logic        cpu_req_valid, cpu_req_ready, cpu_req_we, cpu_req_unsigned;
  logic [1:0]  cpu_req_size;
  logic [31:0] cpu_req_addr, cpu_req_wdata;
  logic        cpu_resp_valid, cpu_resp_ready, cpu_resp_error;
  logic [31:0] cpu_resp_rdata;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  logic [7:0]  mem [0:1023];
  logic [17:0] wlog [$];
  logic [32:0] exp_q [$];
  vec_t        vt [$];
  int          checks = 0;
  int          errors = 0;

  load_store_unit #(.MEM_ADDR_W(10)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cpu_req_valid    (cpu_req_valid),
    .cpu_req_ready    (cpu_req_ready),
    .cpu_req_we       (cpu_req_we),
    .cpu_req_size     (cpu_req_size),
    .cpu_req_unsigned (cpu_req_unsigned),
    .cpu_req_addr     (cpu_req_addr),
    .cpu_req_wdata    (cpu_req_wdata),
    .cpu_resp_valid   (cpu_resp_valid),
    .cpu_resp_ready   (cpu_resp_ready),
    .cpu_resp_rdata   (cpu_resp_rdata),
    .cpu_resp_error   (cpu_resp_error),
    .mem_addr         (mem_addr),
    .mem_we           (mem_we),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .dbg_state        (dbg_state)
  );

  // Clock and memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
  end

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wlog.push_back({mem_addr, mem_wdata});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic int nb(input logic [1:0] s);
    return (s == SIZE_B) ? 1 : (s == SIZE_H) ? 2 : 4;
  endfunction

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic err, input logic [31:0] rdata);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.err = err; v.rdata = rdata;
    return v;
  endfunction

  // Driver: issue one request from a negedge in IDLE, track latency and write count,
  // compare the response against the scoreboard entry, complete the handshake.
  task automatic do_req(input vec_t v, input string name);
    int cyc, wr_cnt, lat, wr_exp;
    logic [32:0] exp_v;
    lat    = v.err ? 1 : nb(v.size) + 1;
    wr_exp = (v.we && !v.err) ? nb(v.size) : 0;
    exp_q.push_back({v.err, v.rdata});
    chk({name, " req_ready"}, {31'd0, cpu_req_ready}, 32'd1);
    cpu_req_valid = 1'b1; cpu_req_we = v.we; cpu_req_size = v.size;
    cpu_req_unsigned = v.uns; cpu_req_addr = v.addr; cpu_req_wdata = v.wdata;
    @(posedge clk);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    cyc = 1; wr_cnt = 0;
    while (cyc < 20) begin
      if (mem_we) wr_cnt++;
      if (cpu_resp_valid) break;
      @(negedge clk);
      cyc++;
    end
    chk({name, " latency"}, 32'(cyc), 32'(lat));
    chk({name, " write_count"}, 32'(wr_cnt), 32'(wr_exp));
    if (exp_q.size() == 0) begin
      chk({name, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      exp_v = exp_q.pop_front();
      chk({name, " error"}, {31'd0, cpu_resp_error}, {31'd0, exp_v[32]});
      chk({name, " rdata"}, cpu_resp_rdata, exp_v[31:0]);
    end
    @(negedge clk);
    chk({name, " resp_valid_cleared"}, {31'd0, cpu_resp_valid}, 32'd0);
  endtask

  initial begin
    int base, a, off, n, sz;
    logic [31:0] wd, raw, exp_r, addr;
    logic uns;

    cpu_req_valid = 0; cpu_req_we = 0; cpu_req_size = 0; cpu_req_unsigned = 0;
    cpu_req_addr = 0; cpu_req_wdata = 0; cpu_resp_ready = 1;
    reset_n = 0;
    repeat (3) @(negedge clk);
    chk("rst req_ready", {31'd0, cpu_req_ready}, 32'd0);
    chk("rst resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
    chk("rst rdata", cpu_resp_rdata, 32'd0);
    chk("rst error", {31'd0, cpu_resp_error}, 32'd0);
    chk("rst mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst state", {30'd0, dbg_state}, 32'd0);
    reset_n = 1;
    @(negedge clk);

    vt.push_back(mk(1, SIZE_W, 0, 32'h010, 32'h12345678, 0, 32'h0));
    vt.push_back(mk(0, SIZE_W, 0, 32'h010, 32'h0, 0, 32'h12345678));
    vt.push_back(mk(1, SIZE_B, 0, 32'h020, 32'h00000080, 0, 32'h0));
    vt.push_back(mk(0, SIZE_B, 0, 32'h020, 32'h0, 0, 32'hFFFFFF80));
    vt.push_back(mk(0, SIZE_B, 1, 32'h020, 32'h0, 0, 32'h00000080));
    vt.push_back(mk(1, SIZE_H, 0, 32'h020, 32'h00008001, 0, 32'h0));
    vt.push_back(mk(0, SIZE_H, 0, 32'h020, 32'h0, 0, 32'hFFFF8001));
    vt.push_back(mk(0, SIZE_H, 1, 32'h020, 32'h0, 0, 32'h00008001));
    vt.push_back(mk(0, SIZE_H, 0, 32'h011, 32'h0, 1, 32'h0));
    vt.push_back(mk(0, SIZE_W, 0, 32'h012, 32'h0, 1, 32'h0));
    vt.push_back(mk(0, SIZE_X, 0, 32'h010, 32'h0, 1, 32'h0));
    vt.push_back(mk(1, SIZE_X, 0, 32'h010, 32'hFFFFFFFF, 1, 32'h0));
    vt.push_back(mk(0, SIZE_W, 0, 32'h010, 32'h0, 0, 32'h12345678));
    vt.push_back(mk(1, SIZE_W, 0, 32'h3FC, 32'hCAFEF00D, 0, 32'h0));
    vt.push_back(mk(0, SIZE_W, 0, 32'h3FC, 32'h0, 0, 32'hCAFEF00D));
    vt.push_back(mk(0, SIZE_W, 0, 32'h400, 32'h0, 1, 32'h0));
    vt.push_back(mk(0, SIZE_B, 0, 32'hFFFF0000, 32'h0, 1, 32'h0));
    vt.push_back(mk(0, SIZE_W, 0, 32'h7FC, 32'h0, 1, 32'h0));
    vt.push_back(mk(0, SIZE_B, 0, 32'h3FF, 32'h0, 0, 32'h0000000D));
    vt.push_back(mk(0, SIZE_B, 0, 32'h3FC, 32'h0, 0, 32'hFFFFFFCA));
    vt.push_back(mk(0, SIZE_H, 0, 32'h3FE, 32'h0, 0, 32'hFFFFF00D));
    vt.push_back(mk(0, SIZE_H, 1, 32'h3FE, 32'h0, 0, 32'h0000F00D));
    vt.push_back(mk(1, SIZE_H, 0, 32'h3FF, 32'h1234, 1, 32'h0));
    vt.push_back(mk(1, SIZE_B, 0, 32'h030, 32'hFFFFFF5A, 0, 32'h0));
    vt.push_back(mk(1, SIZE_H, 0, 32'h032, 32'h1234ABCD, 0, 32'h0));
    vt.push_back(mk(0, SIZE_W, 0, 32'h030, 32'h0, 0, 32'h5A00ABCD));
    vt.push_back(mk(0, SIZE_B, 0, 32'h032, 32'h0, 0, 32'hFFFFFFAB));
    vt.push_back(mk(1, SIZE_B, 0, 32'h042, 32'h11, 0, 32'h0));
    vt.push_back(mk(1, SIZE_B, 0, 32'h043, 32'h22, 0, 32'h0));

    for (int i = 0; i < vt.size(); i++) begin
      base = wlog.size();
      do_req(vt[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        chk("sw order cnt", 32'(wlog.size() - base), 32'd4);
        if (wlog.size() - base == 4) begin
          chk("sw byte0", {14'd0, wlog[base]},     {14'd0, 10'h010, 8'h12});
          chk("sw byte1", {14'd0, wlog[base + 1]}, {14'd0, 10'h011, 8'h34});
          chk("sw byte2", {14'd0, wlog[base + 2]}, {14'd0, 10'h012, 8'h56});
          chk("sw byte3", {14'd0, wlog[base + 3]}, {14'd0, 10'h013, 8'h78});
        end
      end
    end

    // Random word stores read back with random size/offset/extension
    for (int r = 0; r < 8; r++) begin
      a = $urandom_range(64, 254);
      addr = 32'(a * 4);
      wd = $urandom;
      do_req(mk(1, SIZE_W, 0, addr, wd, 0, 32'h0), $sformatf("rnd_sw%0d", r));
      sz = $urandom_range(0, 2);
      uns = 1'($urandom_range(0, 1));
      n = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
      off = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
      raw = wd >> (8 * (4 - off - n));
      if (sz == 0)      exp_r = uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      else if (sz == 1) exp_r = uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      else              exp_r = wd;
      do_req(mk(0, 2'(sz), uns, addr + 32'(off), 32'h0, 0, exp_r), $sformatf("rnd_ld%0d", r));
    end

    // Response stall: held response, no acceptance of a competing request
    base = wlog.size();
    cpu_resp_ready = 0;
    exp_q.push_back({1'b0, 32'h12345678});
    cpu_req_valid = 1; cpu_req_we = 0; cpu_req_size = SIZE_W;
    cpu_req_unsigned = 0; cpu_req_addr = 32'h010; cpu_req_wdata = 0;
    @(posedge clk);
    @(negedge clk);
    cpu_req_we = 1; cpu_req_addr = 32'h050; cpu_req_wdata = 32'hDEADBEEF;
    a = 0;
    while (!cpu_resp_valid && a < 20) begin
      @(negedge clk);
      a++;
    end
    chk("stall resp_seen", 32'(a < 20), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d resp_valid", k), {31'd0, cpu_resp_valid}, 32'd1);
      chk($sformatf("stall%0d rdata", k), cpu_resp_rdata, 32'h12345678);
      chk($sformatf("stall%0d req_ready", k), {31'd0, cpu_req_ready}, 32'd0);
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      exp_r = exp_q.pop_front();
      chk("stall final rdata", cpu_resp_rdata, exp_r);
    end else begin
      chk("stall scoreboard_empty", 32'd1, 32'd0);
    end
    cpu_resp_ready = 1; cpu_req_valid = 0;
    @(negedge clk);
    chk("stall resp_done", {31'd0, cpu_resp_valid}, 32'd0);
    chk("stall no_writes", 32'(wlog.size() - base), 32'd0);
    chk("stall mem050", {24'd0, mem[10'h050]}, 32'd0);

    // Reset during a word store after two bytes are written
    cpu_req_valid = 1; cpu_req_we = 1; cpu_req_size = SIZE_W;
    cpu_req_unsigned = 0; cpu_req_addr = 32'h040; cpu_req_wdata = 32'hAABBCCDD;
    @(posedge clk);
    @(negedge clk);
    cpu_req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 0;
    #1;
    chk("arst mem_we", {31'd0, mem_we}, 32'd0);
    chk("arst resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
    chk("arst req_ready", {31'd0, cpu_req_ready}, 32'd0);
    chk("arst mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("arst mem_wdata", {24'd0, mem_wdata}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("arst post%0d resp_valid", k), {31'd0, cpu_resp_valid}, 32'd0);
      chk($sformatf("arst post%0d req_ready", k), {31'd0, cpu_req_ready}, 32'd1);
    end
    chk("arst mem040", {24'd0, mem[10'h040]}, 32'h000000AA);
    chk("arst mem041", {24'd0, mem[10'h041]}, 32'h000000BB);
    chk("arst mem042", {24'd0, mem[10'h042]}, 32'h00000011);
    chk("arst mem043", {24'd0, mem[10'h043]}, 32'h00000022);
    do_req(mk(0, SIZE_W, 0, 32'h040, 32'h0, 0, 32'hAABB1122), "arst readback");

    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side access sequencer between the MIPS MEM stage and the byte-addressed, big-endian data memory. Accepts one load or store per request (byte, halfword or word), performs it as a sequence of single-byte memory cycles, assembles and sign/zero-extends load data, and returns a response through a valid/ready handshake. Misaligned and out-of-range accesses are rejected without touching memory.

## Interface
Parameters:
- MEM_ADDR_W, 10, byte-address width of the data memory (1024 bytes)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req_valid  in  1  request present
- cpu_req_ready  out  1  unit can accept a request (high only in IDLE)
- cpu_req_we  in  1  1 = store, 0 = load
- cpu_req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- cpu_req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- cpu_req_addr  in  32  byte address
- cpu_req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- cpu_resp_valid  out  1  response present
- cpu_resp_ready  in  1  consumer takes response
- cpu_resp_rdata  out  32  extended load data; 0 for stores and errors
- cpu_resp_error  out  1  misaligned, illegal size or out-of-range
- mem_addr  out  MEM_ADDR_W  byte address to memory
- mem_we  out  1  byte write strobe
- mem_wdata  out  8  byte to write
- mem_rdata  in  8  byte read, combinational from mem_addr

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: cpu_req_ready=1. On cpu_req_valid: latch we, size, unsigned, addr, wdata; byte count n = 1/2/4.
- Error check at acceptance: size 11; half with addr[0]=1; word with addr[1:0]≠00; addr+n-1 ≥ 2**MEM_ADDR_W (addr[31:MEM_ADDR_W] nonzero included). Error -> RESP with error=1, rdata=0, no memory cycle.
- Otherwise -> ACCESS, byte index i=0..n-1; mem_addr = addr[MEM_ADDR_W-1:0]+i.
- Store: byte i = most significant remaining byte of the n-byte field (big-endian): word sends [31:24],[23:16],[15:8],[7:0]; half sends [15:8],[7:0]; byte sends [7:0]. mem_we=1 each ACCESS cycle.
- Load: mem_we=0; mem_rdata shifted into accumulator at each ACCESS edge (acc = {acc[23:0], mem_rdata}).
- After byte n-1 -> RESP. Load rdata: byte/half sign-extended from bit 7/15 unless unsigned; word as-is. Store rdata=0.
- RESP: cpu_resp_valid=1, rdata/error stable until cpu_resp_ready; handshake edge -> IDLE. No new request accepted in RESP.
- cpu_req_* ignored outside IDLE.

## Timing
- Reset values: cpu_req_ready=0 during reset, 1 after (IDLE); cpu_resp_valid=0, cpu_resp_rdata=0, cpu_resp_error=0, mem_addr=0, mem_we=0, mem_wdata=0; state IDLE.
- Accept at edge 0; ACCESS cycles 1..n; cpu_resp_valid high from cycle n+1. Error response valid in cycle 1.
- Minimum request-to-request spacing: n+2 cycles (resp_ready held high).
- mem_addr/mem_we/mem_wdata registered; mem_we never high outside ACCESS.
- Reset asserted mid-ACCESS: mem_we drops immediately (async); bytes already written stay written; no response is produced.
- Address wrap inside memory impossible (range check precedes access).

## Structure
- Package lsu_pkg: size encodings (SIZE_B, SIZE_H, SIZE_W), state enum, byte-count function, extension function.
- One natural sub-module: lsu_extend (combinational sign/zero extension of accumulator by size/unsigned), reused by future cache path.

## Test plan
- Store word 0x12345678 at 0x010 -> mem writes 0x12@0x010, 0x34@0x011, 0x56@0x012, 0x78@0x013 in cycles 1-4; load word 0x010 -> rdata 0x12345678, resp in cycle 5.
- Store byte 0x80 at 0x020; lb 0x020 -> 0xFFFFFF80; lbu 0x020 -> 0x00000080; lh 0x020 after sh 0x8001 -> 0xFFFF8001, lhu -> 0x00008001.
- lh at 0x011, lw at 0x012, size 11 -> error=1, rdata=0, mem_we never asserted, resp in cycle 1.
- sw at 0x3FC accepted; lw at 0x400 and lb at 0xFFFF0000 -> error, no memory cycle.
- cpu_resp_ready low 3 cycles in RESP -> resp_valid, rdata held; cpu_req_ready low; new cpu_req_valid ignored until handshake.
- reset_n low after 2 bytes of sw 0xAABBCCDD at 0x040 -> mem_we=0 immediately, outputs at reset values; 0x040/0x041 = AA/BB, 0x042/0x043 unchanged.
